// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the one-hot to binary encoder.
package encoder_pkg;

  localparam int unsigned ENC_IN_WIDTH_DEF  = 16;
  localparam int unsigned ENC_OUT_WIDTH_DEF = 4;
  // Widest request vector onehot_count accepts; narrower vectors are zero-extended.
  localparam int unsigned ENC_MAX_WIDTH     = 64;

  function automatic int unsigned onehot_count(input logic [ENC_MAX_WIDTH-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < int'(ENC_MAX_WIDTH); i++) begin
      cnt += {31'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/encoder_status_reg.sv
// Registered status for the encoder: index copy, valid flag and sticky error flag.
module encoder_status_reg #(
  parameter int unsigned OUT_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [OUT_WIDTH-1:0] binary_i,
  input  logic                 valid_i,
  input  logic                 err_set_i,
  output logic [OUT_WIDTH-1:0] binary_q_o,
  output logic                 valid_q_o,
  output logic                 err_q_o
);

  logic [OUT_WIDTH-1:0] binary_q;
  logic                 valid_q;
  logic                 err_q;
  logic                 err_d;

  // Error is sticky: only reset clears it.
  always_comb begin
    err_d = err_q | err_set_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      binary_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      binary_q <= binary_i;
      valid_q  <= valid_i;
      err_q    <= err_d;
    end
  end

  assign binary_q_o = binary_q;
  assign valid_q_o  = valid_q;
  assign err_q_o    = err_q;

endmodule

// File: rtl/encoder_16to4.sv
// One-hot to binary encoder with combinational index and registered status.
// Define ENCODER_PRIORITY_EN to encode multi-hot inputs to the highest set bit.
module encoder_16to4 import encoder_pkg::*; #(
  parameter int unsigned IN_WIDTH  = ENC_IN_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [IN_WIDTH-1:0]  encoder_in,
  output logic [OUT_WIDTH-1:0] binary_out,
  output logic [OUT_WIDTH-1:0] binary_out_q,
  output logic                 valid_q,
  output logic                 err_q
);

  int unsigned          hot_cnt;
  logic [OUT_WIDTH-1:0] hi_idx;
  logic                 valid_d;
  logic                 err_set;

  always_comb begin
    hot_cnt = onehot_count(ENC_MAX_WIDTH'(encoder_in));
    // Last match wins, so this is the highest set bit (or the only one).
    hi_idx  = '0;
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      if (encoder_in[i]) hi_idx = OUT_WIDTH'(i);
    end
`ifdef ENCODER_PRIORITY_EN
    binary_out = enable ? hi_idx : '0;
    valid_d    = enable && (hot_cnt != 0);
    err_set    = 1'b0;
`else
    binary_out = (enable && (hot_cnt <= 1)) ? hi_idx : '0;
    valid_d    = enable && (hot_cnt == 1);
    err_set    = enable && (hot_cnt > 1);
`endif
  end

  encoder_status_reg #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_status (
    .clk_i      (clk),
    .rst_i      (reset),
    .binary_i   (binary_out),
    .valid_i    (valid_d),
    .err_set_i  (err_set),
    .binary_q_o (binary_out_q),
    .valid_q_o  (valid_q),
    .err_q_o    (err_q)
  );

endmodule

// File: tb/tb_encoder_16to4.sv
// Directed self-checking bench for encoder_16to4 (default and ENCODER_PRIORITY_EN builds).
module tb_encoder_16to4;

  logic        clk;
  logic        clk_en;
  logic        reset;
  logic        enable;
  logic [15:0] encoder_in;
  logic [3:0]  binary_out;
  logic [3:0]  binary_out_q;
  logic        valid_q;
  logic        err_q;

  int checks;
  int errors;

  encoder_16to4 dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .encoder_in   (encoder_in),
    .binary_out   (binary_out),
    .binary_out_q (binary_out_q),
    .valid_q      (valid_q),
    .err_q        (err_q)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a rising edge, check the combinational index, then the registers.
  task automatic step(input logic en, input logic [15:0] vec, input logic [3:0] exp_bin,
                      input logic exp_valid, input logic exp_err, input string tag);
    enable     = en;
    encoder_in = vec;
    #1;
    check({tag, ".binary_out"}, {28'd0, binary_out}, {28'd0, exp_bin});
    @(posedge clk);
    #1;
    check({tag, ".binary_out_q"}, {28'd0, binary_out_q}, {28'd0, exp_bin});
    check({tag, ".valid_q"}, {31'd0, valid_q}, {31'd0, exp_valid});
    check({tag, ".err_q"}, {31'd0, err_q}, {31'd0, exp_err});
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    clk_en     = 1'b0;
    reset      = 1'b0;
    enable     = 1'b0;
    encoder_in = 16'h0000;

    // Asynchronous reset with the clock stopped.
    #1 reset = 1'b1;
    #2;
    check("rst.binary_out_q", {28'd0, binary_out_q}, 32'd0);
    check("rst.valid_q", {31'd0, valid_q}, 32'd0);
    check("rst.err_q", {31'd0, err_q}, 32'd0);
    reset = 1'b0;
    #2;
    check("rel.binary_out_q", {28'd0, binary_out_q}, 32'd0);
    check("rel.valid_q", {31'd0, valid_q}, 32'd0);
    check("rel.err_q", {31'd0, err_q}, 32'd0);

    clk_en = 1'b1;
    @(posedge clk);
    #1;

    // Disabled: bit 0 request is ignored.
    step(1'b0, 16'h0001, 4'd0, 1'b0, 1'b0, "dis");

    // Bit 0 enabled: index 0 but valid.
    step(1'b1, 16'h0001, 4'd0, 1'b1, 1'b0, "bit0");

    // Walk the one-hot bit from 1 to 15.
    for (int i = 1; i < 16; i++) begin
      logic [15:0] v;
      v = 16'h0001 << i;
      step(1'b1, v, 4'(i), 1'b1, 1'b0, $sformatf("walk%0d", i));
    end

    // All-zero input: index 0, not valid.
    step(1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, "zero");

`ifdef ENCODER_PRIORITY_EN
    step(1'b1, 16'h0104, 4'd8, 1'b1, 1'b0, "multi");
    step(1'b1, 16'h0008, 4'd3, 1'b1, 1'b0, "after");
    step(1'b1, 16'hffff, 4'd15, 1'b1, 1'b0, "allhot");
    step(1'b0, 16'hffff, 4'd0, 1'b0, 1'b0, "dismulti");
`else
    step(1'b1, 16'h0104, 4'd0, 1'b0, 1'b1, "multi");
    step(1'b1, 16'h0008, 4'd3, 1'b1, 1'b1, "after");
    step(1'b0, 16'h0010, 4'd0, 1'b0, 1'b1, "sticky");
`endif

    // Mid-cycle reset clears registers without an edge; combinational path keeps following.
    enable     = 1'b1;
    encoder_in = 16'h0020;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst.err_q", {31'd0, err_q}, 32'd0);
    check("midrst.valid_q", {31'd0, valid_q}, 32'd0);
    check("midrst.binary_out_q", {28'd0, binary_out_q}, 32'd0);
    check("midrst.binary_out", {28'd0, binary_out}, 32'd5);
    @(posedge clk);
    #1;
    check("holdrst.binary_out_q", {28'd0, binary_out_q}, 32'd0);
    check("holdrst.valid_q", {31'd0, valid_q}, 32'd0);
    reset = 1'b0;

    step(1'b1, 16'h0400, 4'd10, 1'b1, 1'b0, "postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
